// File: rtl/data_memory_ctrl.sv
// Single-port 32-bit data memory behind a valid/ready request and response handshake.
// Supports byte, half and word loads and stores, with a fixed read latency and alignment checking.
module data_memory_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [1:0] CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [31:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        offset;
    logic              req_err;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lanes;
    logic [31:0]       rd_shift;
    logic [31:0]       load_data;
    logic [31:0]       result;
    logic              accept;
    logic              mem_we;

    // Request decode: lane enables, lane-aligned store data and extended load data.
    always_comb begin
        word_idx    = req_addr[ADDR_W-1:2];
        offset      = req_addr[1:0];
        req_err     = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && offset[0]) ||
                      ((req_size == 2'b10) && (offset != 2'b00));
        byte_en     = 4'b0000;
        load_data   = 32'd0;
        wdata_lanes = req_wdata << {offset, 3'b000};
        rd_shift    = mem[word_idx] >> {offset, 3'b000};
        unique case (req_size)
            2'b00: begin
                byte_en   = 4'b0001 << offset;
                load_data = req_unsigned ? {24'd0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            2'b01: begin
                byte_en   = 4'b0011 << offset;
                load_data = req_unsigned ? {16'd0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                load_data = rd_shift;
            end
            default: begin
                byte_en   = 4'b0000;
                load_data = 32'd0;
            end
        endcase
        result = (req_we || req_err) ? 32'd0 : load_data;
        accept = req_valid && req_ready_q;
        mem_we = accept && req_we && !req_err;
    end

    // Stores land at the acceptance edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    result_d    = result;
                    err_d       = req_err;
                    req_ready_d = 1'b0;
                    if (READ_LAT > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = result;
                        rsp_err_d   = req_err;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = result_q;
                    rsp_err_d   = err_q;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            result_q    <= 32'd0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed vector table, backpressure and reset
// sequences, then randomized traffic compared against a byte-addressed reference memory.
module tb_data_memory_ctrl;

    localparam int ADDR_W   = 10;
    localparam int READ_LAT = 2;
    localparam int MEM_BYTES = 2 ** ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    data_memory_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       expRdata;
        logic              expErr;
    } vec_t;

    vec_t        vecs [19];
    logic [7:0]  modelMem [MEM_BYTES];
    int          vectorCount;
    int          miscompareCount;
    logic [31:0] gotRdata;
    logic        gotErr;
    int          gotLat;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference model: byte-addressed little-endian memory with the alignment rules.
    function automatic void modelAccess(input logic we, input logic [1:0] size, input logic uns,
                                        input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                                        output logic [31:0] expRdata, output logic expErr);
        int          n;
        logic [31:0] val;
        n        = 1 << size;
        expErr   = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
                   (size == 2'd2 && (addr % 4) != 0);
        expRdata = 32'd0;
        if (!expErr) begin
            if (we) begin
                for (int i = 0; i < n; i++) modelMem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++) val = val | ({24'd0, modelMem[int'(addr) + i]} << (8 * i));
                if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
                expRdata = val;
            end
        end
    endfunction

    // Full transaction starting and ending at a falling edge; inputs are scrambled after
    // acceptance and the response is held off for 'hold' cycles.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                                 input int hold);
        checkOutput("req_ready_before_request", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rsp_ready    = 1'b0;
        @(posedge clk);
        #1;
        req_valid    = 1'($urandom_range(0, 1));
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = ADDR_W'($urandom);
        req_wdata    = $urandom;
        gotLat = 0;
        while (1) begin
            @(negedge clk);
            gotLat++;
            if (rsp_valid === 1'b1) break;
            if (gotLat > 20) break;
        end
        if (gotLat > 20) begin
            checkOutput("response_timeout", 32'd1, 32'd0);
        end else begin
            gotRdata = rsp_rdata;
            gotErr   = rsp_err;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checkOutput("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                checkOutput("hold_rsp_rdata", rsp_rdata, gotRdata);
                checkOutput("hold_rsp_err", {31'd0, rsp_err}, {31'd0, gotErr});
                checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("after_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("after_done_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] expRdata;
        logic        expErr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [ADDR_W-1:0] addr;
        logic [31:0] wdata;

        vectorCount     = 0;
        miscompareCount = 0;
        rst_n        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b0;

        // Directed vectors: {we, size, unsigned, addr, wdata, expected rdata, expected err}.
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 10'h013, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 10'h011, 32'h0,        32'h000000BE, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 10'h012, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 10'h012, 32'h00001234, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        32'h1234BEEF, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 10'h011, 32'h0,        32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 10'h012, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        32'h1234BEEF, 1'b0};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 10'h010, 32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 10'h014, 32'h00000000, 32'h00000000, 1'b0};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 10'h014, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 10'h014, 32'h0,        32'h00000000, 1'b0};
        vecs[14] = '{1'b0, 2'd1, 1'b1, 10'h012, 32'h0,        32'h00001234, 1'b0};
        vecs[15] = '{1'b0, 2'd0, 1'b0, 10'h010, 32'h0,        32'hFFFFFFEF, 1'b0};
        vecs[16] = '{1'b1, 2'd0, 1'b0, 10'h011, 32'h0000007F, 32'h00000000, 1'b0};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 10'h010, 32'h0,        32'h12347FEF, 1'b0};
        vecs[18] = '{1'b0, 2'd1, 1'b0, 10'h010, 32'h0,        32'h00007FEF, 1'b0};

        // Asynchronous reset: outputs clear without waiting for a clock edge.
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);

        // Fill every word so the reference model knows the whole array.
        for (int w = 0; w < MEM_BYTES / 4; w++) begin
            wdata = $urandom;
            addr  = ADDR_W'(4 * w);
            modelAccess(1'b1, 2'd2, 1'b0, addr, wdata, expRdata, expErr);
            applyStimulus(1'b1, 2'd2, 1'b0, addr, wdata, 0);
            checkOutput($sformatf("fill_rdata_%0d", w), gotRdata, 32'd0);
            checkOutput($sformatf("fill_err_%0d", w), {31'd0, gotErr}, 32'd0);
        end

        for (int i = 0; i < 19; i++) begin
            modelAccess(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                        expRdata, expErr);
            applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0);
            checkOutput($sformatf("vec%0d_latency", i), gotLat, READ_LAT);
            checkOutput($sformatf("vec%0d_rdata", i), gotRdata, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d_err", i), {31'd0, gotErr}, {31'd0, vecs[i].expErr});
        end

        // Backpressure: response held for three cycles must stay stable.
        applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 3);
        checkOutput("backpressure_rdata", gotRdata, 32'h12347FEF);
        checkOutput("backpressure_err", {31'd0, gotErr}, 32'd0);

        // Reset during WAIT of a store: no response, but the write survives.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 10'h020;
        req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midreset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("midreset_rsp_err", {31'd0, rsp_err}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("midreset_no_response", {31'd0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        modelAccess(1'b1, 2'd2, 1'b0, 10'h020, 32'h11223344, expRdata, expErr);
        @(negedge clk);
        checkOutput("midreset_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midreset_release_req_ready", {31'd0, req_ready}, 32'd1);
        applyStimulus(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, 0);
        checkOutput("midreset_store_kept", gotRdata, 32'h11223344);
        checkOutput("midreset_store_err", {31'd0, gotErr}, 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            we    = 1'($urandom);
            size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            uns   = 1'($urandom);
            addr  = ADDR_W'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            modelAccess(we, size, uns, addr, wdata, expRdata, expErr);
            applyStimulus(we, size, uns, addr, wdata, $urandom_range(0, 3));
            checkOutput($sformatf("rand%0d_latency", i), gotLat, READ_LAT);
            checkOutput($sformatf("rand%0d_rdata", i), gotRdata, expRdata);
            checkOutput($sformatf("rand%0d_err", i), {31'd0, gotErr}, {31'd0, expErr});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
